// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32I decode stage and ID/EX pipeline register
// Decodes the IF/ID word, bypasses same-cycle writeback, stalls on load-use and registers the result.
module id_ex_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic        id_ready,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    input  logic [31:0] rs1_dout,
    input  logic [31:0] rs2_dout,
    input  logic        wb_write_enable,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_ready,
    input  logic        ex_flush,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_jal,
    output logic        ex_jalr,
    output logic        ex_halt
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Control vector bit positions: {reg_write, mem_read, mem_write, branch, jal, jalr, halt}
    localparam int C_RW = 6;
    localparam int C_MR = 5;
    localparam int C_MW = 4;
    localparam int C_BR = 3;
    localparam int C_JAL = 2;
    localparam int C_JALR = 1;
    localparam int C_HALT = 0;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm;
    logic [6:0]  w_ctl;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic        w_hazard;
    logic        w_load_en;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic        r_funct7b5;
    logic [6:0]  r_ctl;

    assign w_opcode = if_inst[6:0];
    assign w_rs1    = if_inst[19:15];
    assign w_rs2    = if_inst[24:20];
    assign rs1      = w_rs1;
    assign rs2      = w_rs2;

    always_comb begin
        w_imm      = 32'd0;
        w_ctl      = 7'd0;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_imm       = {if_inst[31:12], 12'd0};
                w_ctl[C_RW] = 1'b1;
                w_uses_rs1  = 1'b0;
            end
            OPC_JAL: begin
                w_imm        = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
                w_ctl[C_RW]  = 1'b1;
                w_ctl[C_JAL] = 1'b1;
                w_uses_rs1   = 1'b0;
            end
            OPC_JALR: begin
                w_imm         = {{20{if_inst[31]}}, if_inst[31:20]};
                w_ctl[C_RW]   = 1'b1;
                w_ctl[C_JALR] = 1'b1;
            end
            OPC_LOAD: begin
                w_imm       = {{20{if_inst[31]}}, if_inst[31:20]};
                w_ctl[C_RW] = 1'b1;
                w_ctl[C_MR] = 1'b1;
            end
            OPC_OPIMM: begin
                w_imm       = {{20{if_inst[31]}}, if_inst[31:20]};
                w_ctl[C_RW] = 1'b1;
            end
            OPC_STORE: begin
                w_imm       = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
                w_ctl[C_MW] = 1'b1;
                w_uses_rs2  = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm       = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
                w_ctl[C_BR] = 1'b1;
                w_uses_rs2  = 1'b1;
            end
            OPC_OP: begin
                w_ctl[C_RW] = 1'b1;
                w_uses_rs2  = 1'b1;
            end
            OPC_SYSTEM: w_ctl[C_HALT] = 1'b1;
            default: ;
        endcase
    end

    assign w_rd = w_ctl[C_RW] ? if_inst[11:7] : 5'd0;

    // The register file only shows a write after the edge, so the writeback value is bypassed here.
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 :
                       (wb_write_enable && (wb_rd == w_rs1)) ? wb_data : rs1_dout;
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 :
                       (wb_write_enable && (wb_rd == w_rs2)) ? wb_data : rs2_dout;

    assign w_hazard  = r_valid && r_ctl[C_MR] && (r_rd != 5'd0) && if_valid &&
                       ((w_uses_rs1 && (w_rs1 == r_rd)) || (w_uses_rs2 && (w_rs2 == r_rd)));
    assign w_load_en = !r_valid || ex_ready;
    assign id_ready  = ex_flush || (w_load_en && !w_hazard);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_pc       <= RESET_PC;
            r_rs1_data <= 32'd0;
            r_rs2_data <= 32'd0;
            r_imm      <= 32'd0;
            r_rd       <= 5'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_opcode   <= 7'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_ctl      <= 7'd0;
        end else if (ex_flush || (w_load_en && w_hazard)) begin
            // Bubble: data fields keep their old values, only validity and control are cleared.
            r_valid <= 1'b0;
            r_ctl   <= 7'd0;
            r_rd    <= 5'd0;
        end else if (w_load_en) begin
            r_valid    <= if_valid;
            r_pc       <= if_pc;
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_opcode   <= w_opcode;
            r_funct3   <= if_inst[14:12];
            r_funct7b5 <= if_inst[30];
            r_ctl      <= w_ctl;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_rs1_data  = r_rs1_data;
    assign ex_rs2_data  = r_rs2_data;
    assign ex_imm       = r_imm;
    assign ex_rd        = r_rd;
    assign ex_rs1       = r_rs1;
    assign ex_rs2       = r_rs2;
    assign ex_opcode    = r_opcode;
    assign ex_funct3    = r_funct3;
    assign ex_funct7b5  = r_funct7b5;
    assign ex_reg_write = r_ctl[C_RW];
    assign ex_mem_read  = r_ctl[C_MR];
    assign ex_mem_write = r_ctl[C_MW];
    assign ex_branch    = r_ctl[C_BR];
    assign ex_jal       = r_ctl[C_JAL];
    assign ex_jalr      = r_ctl[C_JALR];
    assign ex_halt      = r_ctl[C_HALT];
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_dout;
    logic [31:0] rs2_dout;
    logic        wb_write_enable;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        ex_flush;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_jal;
    logic        ex_jalr;
    logic        ex_halt;

    id_ex_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready),
        .rs1(rs1), .rs2(rs2), .rs1_dout(rs1_dout), .rs2_dout(rs2_dout),
        .wb_write_enable(wb_write_enable), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jal(ex_jal),
        .ex_jalr(ex_jalr), .ex_halt(ex_halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic [6:0]  ctl;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [6:0] obs_ctl;

    // {reg_write, mem_read, mem_write, branch, jal, jalr, halt}
    assign obs_ctl = {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_jalr, ex_halt};

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [4:0] rd, input logic [6:0] ctl);
        exp_t e;
        e.pc = pc; e.imm = imm; e.d1 = d1; e.d2 = d2; e.rd = rd; e.ctl = ctl;
        return e;
    endfunction

    task automatic present(input logic [31:0] pc, input logic [31:0] inst, input exp_t e);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst;
        pend     = e;
    endtask

    // One clock: push the instruction IF/ID hands over, pop/compare what execute accepts.
    task automatic tick();
        exp_t e;
        bit   took;
        #1;
        took = if_valid && id_ready;
        if (took && !ex_flush) sb.push_back(pend);
        if (ex_valid && (ex_ready || ex_flush)) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_underflow: pc %h accepted, nothing expected", ex_pc);
            end else begin
                e = sb.pop_front();
                if (!ex_flush) begin
                    n_cmp++; if (ex_pc !== e.pc) begin n_bad++; $display("FAIL pc: got %h want %h", ex_pc, e.pc); end
                    n_cmp++; if (ex_imm !== e.imm) begin n_bad++; $display("FAIL imm@%h: got %h want %h", e.pc, ex_imm, e.imm); end
                    n_cmp++; if (ex_rs1_data !== e.d1) begin n_bad++; $display("FAIL rs1_data@%h: got %h want %h", e.pc, ex_rs1_data, e.d1); end
                    n_cmp++; if (ex_rs2_data !== e.d2) begin n_bad++; $display("FAIL rs2_data@%h: got %h want %h", e.pc, ex_rs2_data, e.d2); end
                    n_cmp++; if (ex_rd !== e.rd) begin n_bad++; $display("FAIL rd@%h: got %0d want %0d", e.pc, ex_rd, e.rd); end
                    n_cmp++; if (obs_ctl !== e.ctl) begin n_bad++; $display("FAIL ctl@%h: got %b want %b", e.pc, obs_ctl, e.ctl); end
                end
            end
        end
        @(posedge clk);
        #1;
        if (took) if_valid = 1'b0;
    endtask

    task automatic drain();
        ex_ready = 1'b1;
        for (int i = 0; i < 4 && sb.size() != 0; i++) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; if_valid = 1'b0; if_pc = 32'd0; if_inst = 32'd0;
        ex_ready = 1'b1; ex_flush = 1'b0; wb_write_enable = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        rs1_dout = 32'h100; rs2_dout = 32'h200;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        n_cmp++; if (ex_pc !== RST_PC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", ex_pc, RST_PC); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL reset_id_ready: got %b want 1", id_ready); end
        n_cmp++; if (obs_ctl !== 7'd0 || ex_rd !== 5'd0) begin n_bad++; $display("FAIL reset_ctl: got %b/%0d want 0/0", obs_ctl, ex_rd); end
    endtask

    task automatic test_addi();
        present(32'h10, 32'hFFD00293, mk(32'h10, 32'hFFFFFFFD, 32'd0, 32'h200, 5'd5, 7'b1000000));
        #1;
        n_cmp++; if (rs1 !== 5'd0 || rs2 !== 5'd29) begin n_bad++; $display("FAIL rf_addr: got %0d/%0d want 0/29", rs1, rs2); end
        tick();
        n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid: got %b want 1", ex_valid); end
        n_cmp++; if (ex_opcode !== 7'b0010011 || ex_funct3 !== 3'd0 || ex_funct7b5 !== 1'b1)
            begin n_bad++; $display("FAIL addi_fields: got %b/%0d/%b want 0010011/0/1", ex_opcode, ex_funct3, ex_funct7b5); end
        drain();
    endtask

    task automatic test_bypass();
        rs1_dout = 32'h1; rs2_dout = 32'h1;
        wb_write_enable = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
        present(32'h14, 32'h00738433, mk(32'h14, 32'd0, 32'hDEAD, 32'hDEAD, 5'd8, 7'b1000000));
        tick();
        wb_write_enable = 1'b0;
        present(32'h18, 32'h00738433, mk(32'h18, 32'd0, 32'h1, 32'h1, 5'd8, 7'b1000000));
        tick();
        n_cmp++; if (ex_rs1 !== 5'd7 || ex_rs2 !== 5'd7) begin n_bad++; $display("FAIL ex_rs_idx: got %0d/%0d want 7/7", ex_rs1, ex_rs2); end
        wb_write_enable = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        present(32'h1C, 32'hFFD00293, mk(32'h1C, 32'hFFFFFFFD, 32'd0, 32'h1, 5'd5, 7'b1000000));
        tick();
        wb_write_enable = 1'b0;
        drain();
        rs1_dout = 32'h100; rs2_dout = 32'h200;
    endtask

    task automatic test_load_use();
        present(32'h20, 32'h00012483, mk(32'h20, 32'd0, 32'h100, 32'd0, 5'd9, 7'b1100000));
        tick();
        present(32'h24, 32'h00148533, mk(32'h24, 32'd0, 32'h100, 32'h200, 5'd10, 7'b1000000));
        #1;
        n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL lu_stall_ready: got %b want 0", id_ready); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble: got %b want 0", ex_valid); end
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL lu_resume_ready: got %b want 1", id_ready); end
        tick();
        n_cmp++; if (ex_valid !== 1'b1 || ex_pc !== 32'h24) begin n_bad++; $display("FAIL lu_add_enter: got %b/%h want 1/00000024", ex_valid, ex_pc); end
        drain();
    endtask

    task automatic test_no_stall();
        present(32'h30, 32'h00012483, mk(32'h30, 32'd0, 32'h100, 32'd0, 5'd9, 7'b1100000));
        tick();
        present(32'h34, 32'h000014B7, mk(32'h34, 32'h1000, 32'd0, 32'd0, 5'd9, 7'b1000000));
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL lui_no_stall: got %b want 1", id_ready); end
        tick();
        present(32'h38, 32'h00012003, mk(32'h38, 32'd0, 32'h100, 32'd0, 5'd0, 7'b1100000));
        tick();
        present(32'h3C, 32'h00100533, mk(32'h3C, 32'd0, 32'd0, 32'h200, 5'd10, 7'b1000000));
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL x0_no_stall: got %b want 1", id_ready); end
        tick();
        drain();
    endtask

    task automatic test_back_to_back();
        present(32'h60, 32'hFE512E23, mk(32'h60, 32'hFFFFFFFC, 32'h100, 32'h200, 5'd0, 7'b0010000));
        tick();
        present(32'h64, 32'h001000EF, mk(32'h64, 32'h800, 32'd0, 32'h200, 5'd1, 7'b1000100));
        tick();
        present(32'h68, 32'h00000073, mk(32'h68, 32'd0, 32'd0, 32'd0, 5'd0, 7'b0000001));
        tick();
        present(32'h6C, 32'hFFFFFFFF, mk(32'h6C, 32'd0, 32'h100, 32'h200, 5'd0, 7'b0000000));
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        present(32'h40, 32'h00208463, mk(32'h40, 32'h8, 32'h100, 32'h200, 5'd0, 7'b0001000));
        tick();
        ex_ready = 1'b0;
        present(32'h44, 32'hFFD00293, mk(32'h44, 32'hFFFFFFFD, 32'd0, 32'h200, 5'd5, 7'b1000000));
        wb_write_enable = 1'b1; wb_rd = 5'd1; wb_data = 32'h5555;
        #1;
        n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %b want 0", id_ready); end
        tick();
        n_cmp++; if (ex_valid !== 1'b1 || ex_pc !== 32'h40 || ex_branch !== 1'b1)
            begin n_bad++; $display("FAIL bp_hold: got %b/%h/%b want 1/00000040/1", ex_valid, ex_pc, ex_branch); end
        n_cmp++; if (ex_rs1_data !== 32'h100 || ex_imm !== 32'h8)
            begin n_bad++; $display("FAIL bp_hold_data: got %h/%h want 00000100/00000008", ex_rs1_data, ex_imm); end
        wb_write_enable = 1'b0;
        ex_flush = 1'b1;
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", id_ready); end
        tick();
        ex_flush = 1'b0;
        n_cmp++; if (ex_valid !== 1'b0 || ex_branch !== 1'b0)
            begin n_bad++; $display("FAIL flush_bubble: got %b/%b want 0/0", ex_valid, ex_branch); end
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL post_flush_ready: got %b want 1", id_ready); end
        tick();
        drain();
    endtask

    task automatic test_async_reset();
        present(32'h50, 32'hFFD00293, mk(32'h50, 32'hFFFFFFFD, 32'd0, 32'h200, 5'd5, 7'b1000000));
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL async_valid: got %b want 0", ex_valid); end
        n_cmp++; if (ex_pc !== RST_PC) begin n_bad++; $display("FAIL async_pc: got %h want %h", ex_pc, RST_PC); end
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL async_release_ready: got %b want 1", id_ready); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_no_stall();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register of the pipelined RV32I core. It sits between the IF/ID register and the execute stage. It drives the register-file read addresses and consumes the asynchronous read data. It bypasses the same-cycle writeback value the register file cannot yet show, detects load-use hazards, generates immediates and control, and holds everything in a stallable, flushable pipeline register.

## Interface
Parameters:
- `RESET_PC`, 32'h0: value of `ex_pc` while reset is asserted.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `if_valid` in 1: IF/ID holds a valid instruction.
- `if_pc` in 32: PC of the IF/ID instruction.
- `if_inst` in 32: IF/ID instruction word.
- `id_ready` out 1: stage consumes the IF/ID instruction this cycle; IF/ID advances only when 1.
- `rs1`, `rs2` out 5: register-file read addresses, combinational from `if_inst[19:15]` and `if_inst[24:20]`.
- `rs1_dout`, `rs2_dout` in 32: register-file asynchronous read data.
- `wb_write_enable` in 1: writeback write strobe (same signal driving the register file).
- `wb_rd` in 5: writeback destination.
- `wb_data` in 32: writeback data.
- `ex_ready` in 1: execute stage accepts the ID/EX contents this cycle.
- `ex_flush` in 1: branch/jump redirect; kill the ID/EX and IF/ID instructions.
- `ex_valid` out 1: ID/EX holds a valid instruction.
- `ex_pc` out 32: PC of the instruction.
- `ex_rs1_data`, `ex_rs2_data` out 32: operand values.
- `ex_imm` out 32: sign-extended immediate.
- `ex_rd` out 5: destination; 0 when `ex_reg_write`=0.
- `ex_rs1`, `ex_rs2` out 5: source indices for execute-stage forwarding.
- `ex_opcode` out 7, `ex_funct3` out 3, `ex_funct7b5` out 1: instruction fields.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_jal`, `ex_jalr`, `ex_halt` out 1: control signals.

## Operation
- Decode classes by opcode:
  - LUI 0110111 and AUIPC 0010111: U-type.
  - JAL 1101111: J-type.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011: I-type.
  - STORE 0100011: S-type.
  - BRANCH 1100011: B-type.
  - OP 0110011: no immediate; `ex_imm`=0.
  - SYSTEM 1110011: sets `ex_halt`.
  - Unknown opcodes decode as a NOP with valid=1 and all control signals 0.
- `reg_write` is set for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP. `rd` is forced to 0 when `reg_write`=0.
- Source use:
  - uses_rs1: every class except LUI, AUIPC and JAL.
  - uses_rs2: OP, STORE and BRANCH.
- Operand select, per source: if the index is 0, the value is 0. Otherwise, if `wb_write_enable` and `wb_rd`==index, the value is `wb_data`. Otherwise it is `rs*_dout`.
- Load-use hazard: `ex_valid` && `ex_mem_read` && `ex_rd`!=0 && `if_valid`, and the ID/EX rd matches a used source of the IF/ID instruction.
- load_en = !`ex_valid` || `ex_ready`.
- Register update per edge, highest priority first:
  1. `ex_flush`=1: load a bubble. `ex_valid`=0 and all control signals 0; data fields don't-care, kept at their old values.
  2. Else, if load_en && hazard: load a bubble.
  3. Else, if load_en: load the decoded IF/ID instruction, with `ex_valid`=`if_valid`.
  4. Else: hold.
- `id_ready` = `ex_flush` || (load_en && !hazard). It is combinational.
- Reset: all outputs 0 except `ex_pc`=`RESET_PC`. `ex_valid`=0, so `id_ready`=1 once reset is released.

## Timing
- Latency: one cycle from IF/ID to ID/EX. The only combinational paths are `rs1`/`rs2` and `id_ready`.
- Bypass covers exactly the cycle in which the register file is written. An instruction read in that cycle receives the new value.
- Load-use: exactly one bubble when execute does not stall. The instruction is consumed on the next accepting cycle, when the load has left ID/EX.
- Backpressure: while `ex_valid` && !`ex_ready`, all ID/EX outputs hold stable and `id_ready`=0, unless `ex_flush`=1.
- `ex_flush` in the same cycle as a hazard or backpressure: flush wins, a bubble is loaded, and `id_ready`=1.
- Bypass data is captured at the load edge only. A writeback during a held cycle does not update held operands; execute-stage forwarding covers that case.
- Reset asserted mid-operation clears `ex_valid` immediately, without waiting for a clock edge. There is no partial state.

## Test plan
- Reset: hold `reset`=0, then release → `ex_valid`=0, `ex_pc`=`RESET_PC`, `id_ready`=1.
- `addi x5,x0,-3` (32'hFFD00293) at pc 32'h10 → next cycle `ex_imm`=32'hFFFFFFFD, `ex_rd`=5, `ex_reg_write`=1, `ex_rs1_data`=0.
- WB writes x7=32'hDEAD with `rs1_dout`=32'h1 stale, while `add x8,x7,x7` is decoded → `ex_rs1_data`=`ex_rs2_data`=32'hDEAD.
- `lw x9,0(x2)` followed by `add x10,x9,x1` → one bubble cycle (`ex_valid`=0, `id_ready`=0), then the add enters ID/EX.
- Same load followed by `lui x9,1` → no stall. Same load followed by a use of x0 → no stall.
- `ex_ready`=0 for 3 cycles with a valid `beq` held → outputs stable. Assert `ex_flush` in cycle 2 → bubble loaded and `id_ready`=1 that cycle.
